mem_bank_cfg_writer: RTL and testbench

// - Initiator side of the memory-bank configuration bus: owns the bl/wl pins that

---
 rtl/mem_bank_cfg_pkg.sv | 21 ++
 rtl/mem_bank_pulse_timer.sv | 23 ++
 rtl/mem_bank_cfg_writer.sv | 121 ++++++++++++
 tb/tb_mem_bank_cfg_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_cfg_pkg.sv
// mem_bank_cfg_pkg: shared state encoding and fabric width defaults for the
// memory-bank configuration writer.
package mem_bank_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int BL_WIDTH_DEF = 3;
    localparam int WL_WIDTH_DEF = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mem_bank_pulse_timer.sv
// mem_bank_pulse_timer: loadable down-counter that stops at zero and flags it.
module mem_bank_pulse_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    assign o_zero = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= i_load ? i_load_val : (o_zero ? r_cnt : r_cnt - W'(1));
    end

endmodule

// File: rtl/mem_bank_cfg_writer.sv
// mem_bank_cfg_writer: drives bl/wl of the memory-bank configuration bus,
// one row per handshake as bl setup, one-hot wl pulse, bl hold.
module mem_bank_cfg_writer
    import mem_bank_cfg_pkg::*;
#(
    parameter int BL_WIDTH     = BL_WIDTH_DEF,
    parameter int WL_WIDTH     = WL_WIDTH_DEF,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                        prog_clk,
    input  logic                        prog_rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(WL_WIDTH)-1:0] cfg_row,
    input  logic [BL_WIDTH-1:0]         cfg_data,
    input  logic                        cfg_last,
    output logic [0:BL_WIDTH-1]         bl,
    output logic [0:WL_WIDTH-1]         wl,
    output logic                        busy,
    output logic                        done,
    output logic                        err_row
);

    localparam int TW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);
    localparam int RW = $clog2(WL_WIDTH);

    state_t              r_state;
    state_t              w_next;
    logic [BL_WIDTH-1:0] r_data;
    logic [BL_WIDTH-1:0] r_bl;
    logic [BL_WIDTH-1:0] w_data_n;
    logic [RW-1:0]       r_row;
    logic                r_last;
    logic [WL_WIDTH-1:0] r_wl;
    logic [WL_WIDTH-1:0] w_onehot;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                w_fire;
    logic                w_row_ok;
    logic                w_zero;
    logic                w_load;
    logic [TW-1:0]       w_load_val;

    assign w_fire   = cfg_valid && r_ready;
    assign w_row_ok = 32'(cfg_row) < WL_WIDTH;
    assign w_data_n = w_fire ? cfg_data : r_data;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_fire && w_row_ok) w_next = ST_SETUP;
            ST_SETUP: if (w_zero) w_next = ST_PULSE;
            ST_PULSE: if (w_zero) w_next = ST_HOLD;
            default:  if (w_zero) w_next = ST_IDLE;
        endcase
    end

    // Every transition enters a different state, so a state change is the load strobe.
    assign w_load     = (w_next != r_state);
    assign w_load_val = (w_next == ST_SETUP) ? TW'(SETUP_CYCLES - 1) :
                        (w_next == ST_PULSE) ? TW'(PULSE_CYCLES - 1) :
                        (w_next == ST_HOLD)  ? TW'(HOLD_CYCLES - 1)  : '0;

    mem_bank_pulse_timer #(.W(TW)) u_timer (
        .i_clk      (prog_clk),
        .i_rst_n    (prog_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    for (genvar i = 0; i < WL_WIDTH; i++) begin : g_wl
        assign w_onehot[i] = (32'(r_row) == i);
        assign wl[i]       = r_wl[i];
    end

    for (genvar i = 0; i < BL_WIDTH; i++) begin : g_bl
        assign bl[i] = r_bl[i];
    end

    // Outputs are registered from the next state so they line up with the phase.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_row   <= '0;
            r_last  <= 1'b0;
            r_bl    <= '0;
            r_wl    <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_fire) begin
                r_data <= cfg_data;
                r_row  <= cfg_row;
                r_last <= cfg_last;
            end
            r_bl    <= (w_next != ST_IDLE) ? w_data_n : '0;
            r_wl    <= (w_next == ST_PULSE) ? w_onehot : '0;
            r_ready <= (w_next == ST_IDLE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_HOLD && w_zero && r_last) ||
                       (w_fire && !w_row_ok && cfg_last);
            if (w_fire && !w_row_ok)
                r_err <= 1'b1;
        end
    end

    assign cfg_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_row   = r_err;

endmodule

// File: tb/tb_mem_bank_cfg_writer.sv
// tb_mem_bank_cfg_writer: default-timing instance plus a 2/3/2 timing instance,
// checked by a per-instance monitor against a queue of expected row writes.
module tb_mem_bank_cfg_writer;

    localparam int S0 = 1, P0 = 2, H0 = 1;
    localparam int S1 = 2, P1 = 3, H1 = 2;

    typedef struct {
        int         row;
        logic [2:0] data;
        logic       last;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       va, vb;
    logic [1:0] row;
    logic [2:0] data;
    logic       last;
    logic       rdy [2];
    logic       bsy [2];
    logic       dn  [2];
    logic       er  [2];
    logic [0:2] bl  [2];
    logic [0:2] wl  [2];

    txn_t       q [2][$];
    logic [8:0] tile_ref [2];
    logic [8:0] tile_mon [2];
    int         exp_done [2];
    int         seen_done [2];
    logic       exp_err [2];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mem_bank_cfg_writer #(.BL_WIDTH(3), .WL_WIDTH(3), .SETUP_CYCLES(S0),
                          .PULSE_CYCLES(P0), .HOLD_CYCLES(H0)) u_a (
        .prog_clk(clk), .prog_rst_n(rst_n), .cfg_valid(va), .cfg_ready(rdy[0]),
        .cfg_row(row), .cfg_data(data), .cfg_last(last), .bl(bl[0]), .wl(wl[0]),
        .busy(bsy[0]), .done(dn[0]), .err_row(er[0]));

    mem_bank_cfg_writer #(.BL_WIDTH(3), .WL_WIDTH(3), .SETUP_CYCLES(S1),
                          .PULSE_CYCLES(P1), .HOLD_CYCLES(H1)) u_b (
        .prog_clk(clk), .prog_rst_n(rst_n), .cfg_valid(vb), .cfg_ready(rdy[1]),
        .cfg_row(row), .cfg_data(data), .cfg_last(last), .bl(bl[1]), .wl(wl[1]),
        .busy(bsy[1]), .done(dn[1]), .err_row(er[1]));

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // bl/wl index i maps to packed bit i so values read like cfg_data.
    function automatic logic [2:0] pk(input logic [0:2] v);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic clear_model();
        for (int g = 0; g < 2; g++) begin
            q[g].delete();
            tile_ref[g]  = '0;
            tile_mon[g]  = '0;
            exp_done[g]  = 0;
            seen_done[g] = 0;
            exp_err[g]   = 1'b0;
        end
    endtask

    task automatic model(input int g, input int r, input logic [2:0] d, input logic l);
        txn_t t;
        if (r < 3) begin
            t.row = r; t.data = d; t.last = l;
            q[g].push_back(t);
            for (int i = 0; i < 3; i++) tile_ref[g][r*3+i] = d[i];
        end else begin
            exp_err[g] = 1'b1;
        end
        if (l) exp_done[g]++;
    endtask

    task automatic send(input int r, input logic [2:0] d, input logic l, input bit to_b);
        int n;
        n = 0;
        @(negedge clk);
        while (!(rdy[0] && (!to_b || rdy[1]))) begin
            n++;
            if (n > 100) begin
                check("ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        va = 1'b1; vb = to_b; row = 2'(r); data = d; last = l;
        @(posedge clk);
        model(0, r, d, l);
        if (to_b) model(1, r, d, l);
        #1 va = 1'b0; vb = 1'b0;
    endtask

    // Cycle k after the handshake: bl in 1..S+P+H, wl in S+1..S+P, done/ready at S+P+H+1.
    task automatic trace(input int r, input logic [2:0] d, input logic l);
        send(r, d, l, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("trace_bl", pk(bl[0]), (k <= S0+P0+H0) ? d : 0);
            check("trace_wl", pk(wl[0]), (k > S0 && k <= S0+P0) ? (1 << r) : 0);
            check("trace_done", dn[0], (k == S0+P0+H0+1) && l);
            check("trace_ready", rdy[0], k > S0+P0+H0);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int PW  = g ? P1 : P0;
        localparam int TOT = g ? S1+P1+H1 : S0+P0+H0;
        initial begin
            logic [2:0] wp, bp, w, b;
            int width, blen, rr;
            txn_t t;
            wp = '0; bp = '0; width = 0; blen = 0;
            forever begin
                @(negedge clk);
                w = pk(wl[g]);
                b = pk(bl[g]);
                if (!rst_n) begin
                    wp = '0; bp = '0; width = 0; blen = 0;
                end else begin
                    if (w != 0) check("wl_onehot", $countones(w), 1);
                    if (w != 0 || wp != 0) check("bl_stable_under_wl", b, bp);
                    if (w != 0) begin
                        width++;
                        if (wp != 0) check("wl_steady", w, wp);
                    end else if (wp != 0) begin
                        rr = $clog2(wp);
                        if (q[g].size() == 0) begin
                            check("wl_unexpected", 1, 0);
                        end else begin
                            t = q[g].pop_front();
                            check("wl_row", rr, t.row);
                            check("bl_data", bp, t.data);
                            check("wl_width", width, PW);
                        end
                        for (int i = 0; i < 3; i++) tile_mon[g][rr*3+i] = bp[i];
                        width = 0;
                    end
                    if (bsy[g]) blen++;
                    else if (blen != 0) begin
                        check("busy_len", blen, TOT);
                        blen = 0;
                    end
                    if (dn[g]) seen_done[g]++;
                    wp = w;
                    bp = b;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        va = 1'b0; vb = 1'b0; row = '0; data = '0; last = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_bl", pk(bl[g]), 0);
            check("rst_wl", pk(wl[g]), 0);
            check("rst_ready", rdy[g], 1);
            check("rst_busy", bsy[g], 0);
            check("rst_done", dn[g], 0);
            check("rst_err", er[g], 0);
        end

        trace(1, 3'b101, 1'b1);

        @(negedge clk);
        va = 1'b1; row = 2'd0; data = 3'b011; last = 1'b0;
        @(posedge clk);
        model(0, 0, 3'b011, 1'b0);
        #1 row = 2'd2; data = 3'b110;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[0] && n < 50);
        @(posedge clk);
        model(0, 2, 3'b110, 1'b0);
        #1 va = 1'b0;
        check("b2b_spacing", n, S0+P0+H0+1);

        send(3, 3'b111, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("oor_err", er[0], 1);
            check("oor_bl", pk(bl[0]), 0);
            check("oor_wl", pk(wl[0]), 0);
            check("oor_ready", rdy[0], 1);
        end
        check("oor_done_count", seen_done[0], exp_done[0]);

        send(0, 3'b010, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("dir_queue_empty", q[0].size(), 0);
        check("dir_tile", tile_mon[0], tile_ref[0]);
        check("dir_err_sticky", er[0], 1);

        send(1, 3'b111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_wl", pk(wl[0]), 3'b010);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_bl", pk(bl[0]), 0);
        check("async_rst_wl", pk(wl[0]), 0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", rdy[0], 1);
        check("post_rst_busy", bsy[0], 0);
        check("post_rst_err", er[0], 0);

        repeat (40) begin
            send($urandom_range(0, 3), 3'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("final_queue_empty", q[g].size(), 0);
            check("final_done_count", seen_done[g], exp_done[g]);
            check("final_err", er[g], exp_err[g]);
            check("final_tile", tile_mon[g], tile_ref[g]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
